// File: rtl/serial_mult_ctrl.sv
// serial_mult_ctrl: sequencer around a bit-serial multiplier core.
// Takes a parallel operand pair, streams it LSB-first into the multiplier,
// gathers the serial product back into a parallel word and hands it downstream.
module serial_mult_ctrl #(
    parameter int NB_DATA_IN  = 4,
    parameter int NB_DATA_OUT = 8,
    parameter int MULT_LAT    = 1,
    parameter bit SIGNED      = 1'b0
) (
    input  logic                   clk,
    input  logic                   i_rst,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [NB_DATA_IN-1:0]  i_data_a,
    input  logic [NB_DATA_IN-1:0]  i_data_b,
    output logic                   o_mult_rst,
    output logic                   o_mult_en,
    output logic                   o_mult_a,
    output logic                   o_mult_b,
    input  logic                   i_mult_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [NB_DATA_OUT-1:0] o_data,
    output logic                   o_busy
);

    // RUN lasts long enough to push every operand/pad bit and collect every product bit
    localparam int LAST_CNT = NB_DATA_OUT + MULT_LAT - 1;
    localparam int CNT_W    = $clog2(LAST_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_CNT);
    localparam logic [CNT_W-1:0] CNT_LAT  = CNT_W'(MULT_LAT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NB_DATA_IN-1:0]  a_q, a_d;
    logic [NB_DATA_IN-1:0]  b_q, b_d;
    logic [NB_DATA_OUT-1:0] res_q, res_d;
    logic [NB_DATA_OUT-1:0] data_q, data_d;

    logic                   pad_a;
    logic                   pad_b;
    logic                   capture;
    logic [NB_DATA_OUT-1:0] res_shift;

    // Pad bits past the operand MSB: sign extension when signed, zero otherwise
    always_comb begin
        pad_a     = SIGNED ? a_q[NB_DATA_IN-1] : 1'b0;
        pad_b     = SIGNED ? b_q[NB_DATA_IN-1] : 1'b0;
        capture   = (state_q == RUN) && (cnt_q >= CNT_LAT);
        res_shift = {i_mult_data, res_q[NB_DATA_OUT-1:1]};
    end

    // Next-state and output decode for the IDLE/CLEAR/RUN/DONE sequence
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        res_d      = res_q;
        data_d     = data_q;
        o_ready    = 1'b0;
        o_valid    = 1'b0;
        o_mult_rst = 1'b0;
        o_mult_en  = 1'b0;
        o_mult_a   = 1'b0;
        o_mult_b   = 1'b0;

        case (state_q)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    a_d     = i_data_a;
                    b_d     = i_data_b;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                cnt_d   = '0;
                res_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                o_mult_rst = 1'b1;
                o_mult_en  = 1'b1;
                o_mult_a   = a_q[0];
                o_mult_b   = b_q[0];
                a_d        = {pad_a, a_q[NB_DATA_IN-1:1]};
                b_d        = {pad_b, b_q[NB_DATA_IN-1:1]};
                cnt_d      = cnt_q + CNT_W'(1);
                if (capture) begin
                    res_d = res_shift;
                end
                if (cnt_q == CNT_LAST) begin
                    data_d  = res_shift;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, operand shifters, result collector and output word; reset aborts any product
    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            data_q  <= data_d;
        end
    end

    assign o_data = data_q;
    assign o_busy = (state_q != IDLE);

endmodule

// File: tb/tb_serial_mult_ctrl.sv
// tb_serial_mult_ctrl: directed bench for serial_mult_ctrl with a behavioural
// one-cycle-latency serial multiplier behind two controllers (unsigned and signed).
module tb_serial_mult_ctrl;

    logic       clk;
    logic       rstN;
    logic       iValid;
    logic       iReady;
    logic [3:0] dataA;
    logic [3:0] dataB;

    logic       readyU, validU, busyU;
    logic [7:0] dataU;
    logic       readyS, validS, busyS;
    logic [7:0] dataS;

    logic       multRst  [2];
    logic       multEn   [2];
    logic       multA    [2];
    logic       multB    [2];
    logic       multData [2];

    int errors = 0;
    int checks = 0;

    serial_mult_ctrl #(
        .NB_DATA_IN (4),
        .NB_DATA_OUT(8),
        .MULT_LAT   (1),
        .SIGNED     (1'b0)
    ) dutU (
        .clk        (clk),
        .i_rst      (rstN),
        .i_valid    (iValid),
        .o_ready    (readyU),
        .i_data_a   (dataA),
        .i_data_b   (dataB),
        .o_mult_rst (multRst[0]),
        .o_mult_en  (multEn[0]),
        .o_mult_a   (multA[0]),
        .o_mult_b   (multB[0]),
        .i_mult_data(multData[0]),
        .o_valid    (validU),
        .i_ready    (iReady),
        .o_data     (dataU),
        .o_busy     (busyU)
    );

    serial_mult_ctrl #(
        .NB_DATA_IN (4),
        .NB_DATA_OUT(8),
        .MULT_LAT   (1),
        .SIGNED     (1'b1)
    ) dutS (
        .clk        (clk),
        .i_rst      (rstN),
        .i_valid    (iValid),
        .o_ready    (readyS),
        .i_data_a   (dataA),
        .i_data_b   (dataB),
        .o_mult_rst (multRst[1]),
        .o_mult_en  (multEn[1]),
        .o_mult_a   (multA[1]),
        .o_mult_b   (multB[1]),
        .i_mult_data(multData[1]),
        .o_valid    (validS),
        .i_ready    (iReady),
        .o_data     (dataS),
        .o_busy     (busyS)
    );

    // Behavioural serial multiplier: rebuilds the operands as bits arrive and
    // returns product bit k one cycle after operand bit k was presented
    for (genvar g = 0; g < 2; g++) begin : gModel
        logic [3:0] kQ;
        logic [7:0] accAQ, accBQ;
        logic [7:0] accAN, accBN, prodN;
        logic       outQ;

        always_comb begin
            accAN = accAQ;
            accBN = accBQ;
            if (kQ < 4'd8) begin
                accAN[kQ[2:0]] = multA[g];
                accBN[kQ[2:0]] = multB[g];
            end
            prodN = accAN * accBN;
        end

        always_ff @(posedge clk or negedge rstN) begin
            if (!rstN) begin
                kQ    <= '0;
                accAQ <= '0;
                accBQ <= '0;
                outQ  <= 1'b0;
            end else if (!multRst[g]) begin
                kQ    <= '0;
                accAQ <= '0;
                accBQ <= '0;
                outQ  <= 1'b0;
            end else if (multEn[g]) begin
                accAQ <= accAN;
                accBQ <= accBN;
                outQ  <= (kQ < 4'd8) ? prodN[kQ[2:0]] : 1'b0;
                if (kQ != 4'd15) begin
                    kQ <= kQ + 4'd1;
                end
            end
        end

        assign multData[g] = outQ;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic valid, input logic ready);
        dataA  = a;
        dataB  = b;
        iValid = valid;
        iReady = ready;
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Offer one pair for a single cycle, then count edges from the accept edge
    // until o_valid is seen (bounded so a stuck design still reaches the summary)
    task automatic acceptAndWait(input logic [3:0] a, input logic [3:0] b, input logic ready, output int n);
        applyStimulus(a, b, 1'b1, ready);
        tick;
        n = 1;
        iValid = 1'b0;
        while (validU !== 1'b1 && n < 40) begin
            tick;
            n++;
        end
    endtask

    initial begin
        int n;
        int w;
        int extra;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [7:0] expProd;

        rstN = 1'b0;
        applyStimulus(4'd0, 4'd0, 1'b0, 1'b0);
        @(negedge clk);

        $display("[TB] reset state");
        checkOutput("rst_ready",    32'(readyU),     32'd1);
        checkOutput("rst_valid",    32'(validU),     32'd0);
        checkOutput("rst_data",     32'(dataU),      32'd0);
        checkOutput("rst_mult_rst", 32'(multRst[0]), 32'd0);
        checkOutput("rst_mult_en",  32'(multEn[0]),  32'd0);
        checkOutput("rst_mult_a",   32'(multA[0]),   32'd0);
        checkOutput("rst_mult_b",   32'(multB[0]),   32'd0);
        checkOutput("rst_busy",     32'(busyU),      32'd0);
        tick;
        rstN = 1'b1;
        tick;

        $display("[TB] 3 x 5 with i_ready high");
        applyStimulus(4'd3, 4'd5, 1'b1, 1'b1);
        tick;
        iValid = 1'b0;
        checkOutput("t1_ready_busy", 32'(readyU), 32'd0);
        checkOutput("t1_busy",       32'(busyU),  32'd1);
        n = 1;
        while (validU !== 1'b1 && n < 40) begin
            tick;
            n++;
        end
        checkOutput("t1_latency", 32'(n),     32'd11);
        checkOutput("t1_data",    32'(dataU), 32'h0F);
        checkOutput("t1_data_s",  32'(dataS), 32'h0F);
        tick;
        checkOutput("t1_valid_pulse", 32'(validU), 32'd0);
        checkOutput("t1_ready_back",  32'(readyU), 32'd1);

        $display("[TB] 8 x 8 unsigned and -8 x -8 signed");
        acceptAndWait(4'b1000, 4'b1000, 1'b1, n);
        checkOutput("t2_latency", 32'(n),     32'd11);
        checkOutput("t2_unsigned", 32'(dataU), 32'h40);
        checkOutput("t2_signed",   32'(dataS), 32'h40);
        checkOutput("t2_valid_s",  32'(validS), 32'd1);
        tick;

        $display("[TB] 15 x 15 with downstream stalled");
        acceptAndWait(4'd15, 4'd15, 1'b0, n);
        checkOutput("t3_latency", 32'(n), 32'd11);
        checkOutput("t3_signed",  32'(dataS), 32'h01);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("t3_valid_hold_%0d", i), 32'(validU), 32'd1);
            checkOutput($sformatf("t3_data_hold_%0d", i),  32'(dataU),  32'hE1);
            tick;
        end
        iReady = 1'b1;
        tick;
        checkOutput("t3_handshake", 32'(validU), 32'd0);
        checkOutput("t3_idle",      32'(busyU),  32'd0);

        $display("[TB] extra i_valid during RUN is ignored");
        applyStimulus(4'd6, 4'd7, 1'b1, 1'b1);
        tick;
        applyStimulus(4'd6, 4'd7, 1'b0, 1'b1);
        tick;
        tick;
        applyStimulus(4'd9, 4'd9, 1'b1, 1'b1);
        checkOutput("t4_ready_run", 32'(readyU), 32'd0);
        tick;
        applyStimulus(4'd9, 4'd9, 1'b0, 1'b1);
        n = 4;
        while (validU !== 1'b1 && n < 40) begin
            tick;
            n++;
        end
        checkOutput("t4_latency", 32'(n),     32'd11);
        checkOutput("t4_data",    32'(dataU), 32'h2A);
        tick;
        extra = 0;
        for (int i = 0; i < 15; i++) begin
            tick;
            if (validU === 1'b1) extra++;
        end
        checkOutput("t4_no_second", 32'(extra), 32'd0);
        checkOutput("t4_idle",      32'(busyU), 32'd0);

        $display("[TB] reset in the middle of RUN");
        applyStimulus(4'd13, 4'd11, 1'b1, 1'b1);
        tick;
        iValid = 1'b0;
        for (int i = 0; i < 4; i++) tick;
        checkOutput("t5_running", 32'(multEn[0]), 32'd1);
        rstN = 1'b0;
        #1;
        checkOutput("t5_ready",    32'(readyU),     32'd1);
        checkOutput("t5_valid",    32'(validU),     32'd0);
        checkOutput("t5_busy",     32'(busyU),      32'd0);
        checkOutput("t5_mult_en",  32'(multEn[0]),  32'd0);
        checkOutput("t5_mult_rst", 32'(multRst[0]), 32'd0);
        checkOutput("t5_mult_a",   32'(multA[0]),   32'd0);
        checkOutput("t5_data",     32'(dataU),      32'd0);
        tick;
        rstN = 1'b1;
        tick;
        acceptAndWait(4'd2, 4'd7, 1'b1, n);
        checkOutput("t5_latency", 32'(n),     32'd11);
        checkOutput("t5_after",   32'(dataU), 32'h0E);
        tick;

        $display("[TB] 100 back-to-back random pairs");
        for (int i = 0; i < 100; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            applyStimulus(ra, rb, 1'b1, 1'b1);
            w = 0;
            while (readyU !== 1'b1 && w < 40) begin
                tick;
                w++;
            end
            expProd = {4'b0, ra} * {4'b0, rb};
            tick;
            n = 1;
            while (validU !== 1'b1 && n < 40) begin
                tick;
                n++;
            end
            checkOutput($sformatf("t6_latency_%0d", i), 32'(n),     32'd11);
            checkOutput($sformatf("t6_data_%0d", i),    32'(dataU), 32'(expProd));
        end
        applyStimulus(4'd0, 4'd0, 1'b0, 1'b1);
        tick;
        tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
